// File: rtl/ace_snoop_driver_if.sv
// ACE snoop channel bundle (AC request, CR response, CD data) between the
// snoop driver (master) and the snooped cache (slave).
interface ace_snoop_driver_if #(
  parameter int unsigned AddrWidth = 64
) ();
  logic                 ac_valid;
  logic                 ac_ready;
  logic [AddrWidth-1:0] ac_addr;
  logic [3:0]           ac_snoop;
  logic [2:0]           ac_prot;
  logic                 cr_valid;
  logic                 cr_ready;
  logic [4:0]           cr_resp;
  logic                 cd_valid;
  logic                 cd_ready;
  logic                 cd_last;

  modport master (
    output ac_valid, ac_addr, ac_snoop, ac_prot, cr_ready, cd_ready,
    input  ac_ready, cr_valid, cr_resp, cd_valid, cd_last
  );

  modport slave (
    input  ac_valid, ac_addr, ac_snoop, ac_prot, cr_ready, cd_ready,
    output ac_ready, cr_valid, cr_resp, cd_valid, cd_last
  );
endinterface

// File: rtl/ace_snoop_driver.sv
// Single-outstanding ACE snoop master: issues one AC per command, collects CR
// and CD, and returns one completion record (response, beat count, errors).
module ace_snoop_driver #(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned CdBeats       = 2,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned BeatW        = $clog2(CdBeats + 1) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [3:0]           cmd_snoop_i,
  ace_snoop_driver_if.master   snoop,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic [4:0]           done_resp_o,
  output logic [BeatW-1:0]     done_beats_o,
  output logic                 done_err_o,
  output logic                 done_tmo_o
);

  localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
  localparam logic [BeatW-1:0] CdBeatsW = BeatW'(CdBeats);

  typedef enum logic [1:0] {IDLE, AC, RSP, DONE} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [3:0]           snoop_q;
  logic [4:0]           resp_q;
  logic [BeatW-1:0]     beats_q;
  logic                 cr_seen_q, last_seen_q, err_q, tmo_q;
  logic [TmoW-1:0]      timer_q;

  logic                 cmd_hs, cr_hs, cd_hs;
  logic [4:0]           resp_eff;
  logic                 cr_seen_eff, last_eff;
  logic [BeatW-1:0]     beats_nxt;
  logic                 err_now, complete, tmo_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    cmd_ready_o       = 1'b0;
    snoop.ac_valid    = 1'b0;
    snoop.cr_ready    = 1'b0;
    snoop.cd_ready    = 1'b0;
    done_valid_o      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = AC;
      end
      AC: begin
        snoop.ac_valid = 1'b1;
        if (snoop.ac_ready) state_d = RSP;
      end
      RSP: begin
        snoop.cr_ready = !cr_seen_q;
        snoop.cd_ready = !last_seen_q;
        if (complete || tmo_fire) state_d = DONE;
      end
      DONE: begin
        done_valid_o = 1'b1;
        if (done_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response collection: "_eff" values include this cycle's handshakes so a
  // CR arriving together with the last CD beat completes in the same cycle.
  always_comb begin
    cmd_hs      = cmd_valid_i && cmd_ready_o;
    cr_hs       = (state_q == RSP) && !cr_seen_q && snoop.cr_valid;
    cd_hs       = (state_q == RSP) && !last_seen_q && snoop.cd_valid;
    resp_eff    = cr_hs ? snoop.cr_resp : resp_q;
    cr_seen_eff = cr_seen_q || cr_hs;
    last_eff    = last_seen_q || (cd_hs && snoop.cd_last);
    beats_nxt   = (cd_hs && (beats_q != '1)) ? beats_q + 1'b1 : beats_q;
    err_now     = (cd_hs && snoop.cd_last && (beats_nxt != CdBeatsW))
               || (cd_hs && !snoop.cd_last && (beats_nxt == CdBeatsW))
               || (cr_hs && snoop.cr_resp[1])
               || (cr_seen_eff && !resp_eff[0] && (beats_nxt != '0));
    complete    = cr_seen_eff && (!resp_eff[0] || last_eff);
    tmo_fire    = (TimeoutCycles != 0) && (timer_q == TmoLast) && !complete;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q      <= '0;
      beats_q     <= '0;
      cr_seen_q   <= 1'b0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      timer_q     <= '0;
    end else if (cmd_hs) begin
      resp_q      <= '0;
      beats_q     <= '0;
      cr_seen_q   <= 1'b0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      timer_q     <= '0;
    end else if (state_q == RSP) begin
      resp_q      <= resp_eff;
      beats_q     <= beats_nxt;
      cr_seen_q   <= cr_seen_eff;
      last_seen_q <= last_eff;
      err_q       <= err_q || err_now || tmo_fire;
      tmo_q       <= tmo_q || tmo_fire;
      if (timer_q != '1) timer_q <= timer_q + 1'b1;
    end
  end

  // Address and opcode are only observed while ac_valid is high, so they
  // need no reset.
  always_ff @(posedge clk_i) begin
    if (cmd_hs) begin
      addr_q  <= {cmd_addr_i[AddrWidth-1:4], 4'b0000};
      snoop_q <= cmd_snoop_i;
    end
  end

  assign snoop.ac_addr  = addr_q;
  assign snoop.ac_snoop = snoop_q;
  assign snoop.ac_prot  = 3'b000;

  assign done_resp_o  = done_valid_o ? resp_q  : '0;
  assign done_beats_o = done_valid_o ? beats_q : '0;
  assign done_err_o   = done_valid_o && err_q;
  assign done_tmo_o   = done_valid_o && tmo_q;

endmodule

// File: tb/tb_ace_snoop_driver.sv
// Randomized bench for ace_snoop_driver: a cycle-driven snoop slave plus a
// transaction-level model predicting each completion record and its latency.
module tb_ace_snoop_driver;
  localparam int AW  = 64;
  localparam int CDB = 2;
  localparam int TMO = 16;
  localparam int BW  = $clog2(CDB + 1) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [3:0]    cmd_snoop = '0;
  logic          done_valid;
  logic          done_ready = 1'b0;
  logic [4:0]    done_resp;
  logic [BW-1:0] done_beats;
  logic          done_err, done_tmo;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ace_snoop_driver_if #(.AddrWidth(AW)) sif ();

  ace_snoop_driver #(.AddrWidth(AW), .CdBeats(CDB), .TimeoutCycles(TMO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_snoop_i  (cmd_snoop),
    .snoop        (sif),
    .done_valid_o (done_valid),
    .done_ready_i (done_ready),
    .done_resp_o  (done_resp),
    .done_beats_o (done_beats),
    .done_err_o   (done_err),
    .done_tmo_o   (done_tmo)
  );

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  snoop;
    int          ac_dly;
    bit          has_cr;
    int          cr_at;
    logic [4:0]  resp;
    int          nbeats;
    int          cd_at;
    int          last_pos;
    int          dr_dly;
    bit          overlap;
  } txn_t;

  typedef struct {
    int         lat;
    logic [4:0] resp;
    int         beats;
    bit         err;
    bit         tmo;
  } exp_t;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic [63:0] addr, input logic [3:0] sn, input int ac_dly,
                              input bit has_cr, input int cr_at, input logic [4:0] resp,
                              input int nb, input int cd_at, input int lp, input int dr_dly,
                              input bit ov);
    txn_t t;
    t.addr = addr; t.snoop = sn; t.ac_dly = ac_dly; t.has_cr = has_cr; t.cr_at = cr_at;
    t.resp = resp; t.nbeats = nb; t.cd_at = cd_at; t.last_pos = lp; t.dr_dly = dr_dly;
    t.overlap = ov;
    return t;
  endfunction

  // Cycle numbers are counted from the first cycle after the AC handshake.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    int   end_c, nb_lim, acc;
    bit   last_ok, cr_acc, tmo;
    end_c   = 1000;
    last_ok = (t.last_pos > 0) && (t.last_pos <= t.nbeats);
    if (t.has_cr) begin
      if (!t.resp[0]) end_c = t.cr_at;
      else if (last_ok) begin
        end_c = t.cd_at + t.last_pos - 1;
        if (t.cr_at > end_c) end_c = t.cr_at;
      end
    end
    tmo = end_c > TMO - 1;
    if (tmo) end_c = TMO - 1;
    cr_acc = t.has_cr && (t.cr_at <= end_c);
    nb_lim = last_ok ? t.last_pos : t.nbeats;
    acc    = end_c - t.cd_at + 1;
    if (acc < 0) acc = 0;
    if (acc > nb_lim) acc = nb_lim;
    e.lat   = end_c + 1;
    e.resp  = cr_acc ? t.resp : 5'd0;
    e.beats = acc;
    e.tmo   = tmo;
    e.err   = tmo
           || (cr_acc && t.resp[1])
           || (last_ok && (acc == t.last_pos) && (t.last_pos != CDB))
           || ((acc >= CDB) && (t.last_pos != CDB))
           || (cr_acc && !t.resp[0] && (acc > 0));
    return e;
  endfunction

  task automatic run_txn(input txn_t t);
    exp_t        e;
    logic [63:0] aligned;
    int          n, k, b, done_k;
    bit          cr_taken;
    e       = model(t);
    aligned = {t.addr[63:4], 4'h0};
    cmd_valid = 1'b1; cmd_addr = t.addr; cmd_snoop = t.snoop;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk); n++;
    end
    if (!cmd_ready) begin
      check_val("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check_val("ac_latency", 64'(sif.ac_valid), 64'd1);
    check_val("ac_addr", sif.ac_addr, aligned);
    check_val("ac_snoop", 64'(sif.ac_snoop), 64'(t.snoop));
    check_val("ac_prot", 64'(sif.ac_prot), 64'd0);
    check_val("busy_cmd_ready", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < t.ac_dly; i++) begin
      @(negedge clk);
      check_val("ac_hold", 64'(sif.ac_valid), 64'd1);
      check_val("ac_hold_addr", sif.ac_addr, aligned);
    end
    sif.ac_ready = 1'b1;
    @(negedge clk);
    sif.ac_ready = 1'b0;

    cr_taken = 1'b0; b = 0; done_k = -1; k = 0;
    while (k < 40) begin
      if (done_valid) begin
        done_k = k;
        break;
      end
      if (k == 0) begin
        check_val("rsp_cr_ready", 64'(sif.cr_ready), 64'd1);
        check_val("rsp_cd_ready", 64'(sif.cd_ready), 64'd1);
      end
      sif.cr_valid = t.has_cr && (k >= t.cr_at) && !cr_taken;
      sif.cr_resp  = t.resp;
      sif.cd_valid = (b < t.nbeats) && (k >= t.cd_at + b);
      sif.cd_last  = (b + 1 == t.last_pos);
      if (sif.cr_valid && sif.cr_ready) cr_taken = 1'b1;
      if (sif.cd_valid && sif.cd_ready) b++;
      @(negedge clk);
      k++;
    end
    sif.cr_valid = 1'b0; sif.cd_valid = 1'b0; sif.cd_last = 1'b0;
    if (done_k < 0) begin
      check_val("done_wait", 64'(done_valid), 64'd1);
      return;
    end
    check_val("done_latency", 64'(done_k), 64'(e.lat));
    check_val("done_resp", 64'(done_resp), 64'(e.resp));
    check_val("done_beats", 64'(done_beats), 64'(e.beats));
    check_val("done_err", 64'(done_err), 64'(e.err));
    check_val("done_tmo", 64'(done_tmo), 64'(e.tmo));

    for (int i = 0; i < t.dr_dly; i++) begin
      cmd_valid = t.overlap;
      cmd_addr  = {$urandom, $urandom};
      cmd_snoop = 4'($urandom);
      @(negedge clk);
      check_val("done_hold_valid", 64'(done_valid), 64'd1);
      check_val("done_hold_resp", 64'(done_resp), 64'(e.resp));
      check_val("done_hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check_val("done_hold_ac_valid", 64'(sif.ac_valid), 64'd0);
    end
    cmd_valid  = 1'b0;
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    check_val("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    check_val("idle_done_valid", 64'(done_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check_val({tag, "_ac_valid"}, 64'(sif.ac_valid), 64'd0);
    check_val({tag, "_cr_ready"}, 64'(sif.cr_ready), 64'd0);
    check_val({tag, "_cd_ready"}, 64'(sif.cd_ready), 64'd0);
    check_val({tag, "_done_valid"}, 64'(done_valid), 64'd0);
    check_val({tag, "_done_fields"}, {done_resp, 3'(done_beats), done_err, done_tmo}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   nb;
    sif.ac_ready = 1'b0; sif.cr_valid = 1'b0; sif.cr_resp = '0;
    sif.cd_valid = 1'b0; sif.cd_last = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // READ_SHARED, data follows CR
    run_txn(mk(64'h8000_0040, 4'b0001, 0, 1, 0, 5'b01001, 2, 1, 2, 0, 0));
    // CLEAN_INVALID, no data, AC stalled three cycles
    run_txn(mk(64'h1234_5678_9abc_def7, 4'b1001, 3, 1, 0, 5'b00000, 0, 0, 0, 1, 0));
    // READ_UNIQUE, data first, CR together with last beat
    run_txn(mk(64'h0000_0000_0000_1000, 4'b0111, 1, 1, 1, 5'b10001, 2, 0, 2, 0, 0));
    // Early last
    run_txn(mk(64'h40, 4'b0001, 0, 1, 0, 5'b00001, 1, 0, 1, 0, 0));
    // Data with no data-transfer response
    run_txn(mk(64'h80, 4'b1001, 0, 1, 0, 5'b00000, 1, 0, 1, 0, 0));
    // Error bit in CR
    run_txn(mk(64'hC0, 4'b0001, 0, 1, 2, 5'b00010, 0, 0, 0, 0, 0));
    // No CR: timeout
    run_txn(mk(64'h100, 4'b0001, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0));
    // Back-to-back with completion stalled and a pending command
    run_txn(mk(64'h200, 4'b0001, 0, 1, 0, 5'b00001, 2, 0, 2, 5, 1));
    run_txn(mk(64'h240, 4'b0111, 0, 1, 3, 5'b10001, 2, 1, 2, 0, 0));

    // Reset while collecting responses
    cmd_valid = 1'b1; cmd_addr = 64'h300; cmd_snoop = 4'b0001;
    @(negedge clk);
    cmd_valid = 1'b0; sif.ac_ready = 1'b1;
    @(negedge clk);
    sif.ac_ready = 1'b0;
    check_val("pre_rst_cr_ready", 64'(sif.cr_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_mid_reset");
    run_txn(mk(64'h340, 4'b0001, 0, 1, 1, 5'b01001, 2, 0, 2, 0, 0));

    for (int i = 0; i < 30; i++) begin
      nb = $urandom_range(0, 3);
      t = mk({$urandom, $urandom}, 4'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 9) != 0), $urandom_range(0, 6), 5'($urandom),
             nb, $urandom_range(0, 6), 0, $urandom_range(0, 3), 1'($urandom));
      t.last_pos = ($urandom_range(0, 3) != 0) ? ((nb >= CDB) ? CDB : nb) : $urandom_range(0, nb);
      run_txn(t);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
